dist_parent_select: RTL and testbench

Selection stage sitting directly downstream of the per-individual route-distance computation. After all 25 distance units report done, it serially scans the 25 route distances, identifies the two shortest (fittest) individuals, and presents their indices, distances and 75-bit chromosomes as the parent pair for the crossover/mutation stage. An optional running sum of all distances supports fitness-proportional statistics.

---
 rtl/dist_parent_select.sv | 124 ++++++++++++
 tb/tb_dist_parent_select.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dist_parent_select.sv
// Parent-pair selection: serially scans N route distances, keeps the two shortest, emits their indices/chromosomes.
// Optional FITNESS_SUM_EN builds a running sum of all distances onto total_dist (tied to 0 otherwise).
module dist_parent_select #(
  parameter int N  = 25,
  parameter int DW = 12,
  parameter int CW = 75,
  parameter int IW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N*CW-1:0] pop,
  input  logic [N*DW-1:0] distances,
  output logic            busy,
  output logic            done,
  output logic [IW-1:0]   best_idx,
  output logic [IW-1:0]   second_idx,
  output logic [DW-1:0]   best_dist,
  output logic [DW-1:0]   second_dist,
  output logic [CW-1:0]   parent_a,
  output logic [CW-1:0]   parent_b,
  output logic [DW+4:0]   total_dist
);

  // state | meaning
  // IDLE  | waiting for start; results hold
  // SCAN  | one distance compared per cycle, index k = 0..N-1
  // DONE  | running best/second transferred to the output registers
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   k;
  logic [DW:0]     min_v, second_v;
  logic [IW-1:0]   min_i, second_i;
  logic [DW-1:0]   d;
  logic            last_k;

  assign d      = distances[k*DW +: DW];
  assign last_k = (k == IW'(N-1));
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (last_k) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The DW+1-bit sentinel 2^DW exceeds any real distance, so the first two samples always land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      min_v    <= '0;
      second_v <= '0;
      min_i    <= '0;
      second_i <= '0;
    end else if (state == S_IDLE && start) begin
      k        <= '0;
      min_v    <= {1'b1, {DW{1'b0}}};
      second_v <= {1'b1, {DW{1'b0}}};
      min_i    <= '0;
      second_i <= '0;
    end else if (state == S_SCAN) begin
      k <= k + IW'(1);
      if ({1'b0, d} < min_v) begin
        second_v <= min_v;
        second_i <= min_i;
        min_v    <= {1'b0, d};
        min_i    <= k;
      end else if ({1'b0, d} < second_v) begin
        second_v <= {1'b0, d};
        second_i <= k;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      best_idx    <= '0;
      second_idx  <= '0;
      best_dist   <= '0;
      second_dist <= '0;
      parent_a    <= '0;
      parent_b    <= '0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        best_idx    <= min_i;
        second_idx  <= second_i;
        best_dist   <= min_v[DW-1:0];
        second_dist <= second_v[DW-1:0];
        parent_a    <= pop[min_i*CW +: CW];
        parent_b    <= pop[second_i*CW +: CW];
      end
    end
  end

`ifdef FITNESS_SUM_EN
  logic [DW+4:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      total_dist <= '0;
    end else begin
      if (state == S_IDLE && start) sum <= '0;
      else if (state == S_SCAN)     sum <= sum + (DW+5)'(d);
      if (state == S_DONE)          total_dist <= sum;
    end
  end
`else
  assign total_dist = '0;
`endif

endmodule

// File: tb/tb_dist_parent_select.sv
// Randomized self-checking bench for dist_parent_select against a sort-style reference model.
module tb_dist_parent_select;
  localparam int N  = 25;
  localparam int DW = 12;
  localparam int CW = 75;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [N*CW-1:0] pop = '0;
  logic [N*DW-1:0] distances = '0;
  logic            busy, done;
  logic [IW-1:0]   best_idx, second_idx;
  logic [DW-1:0]   best_dist, second_dist;
  logic [CW-1:0]   parent_a, parent_b;
  logic [DW+4:0]   total_dist;

  int n_cmp = 0;
  int n_err = 0;
  int dist_arr [N];
  logic [CW-1:0] chrom [N];

  always #5 clk = ~clk;

  dist_parent_select #(.N(N), .DW(DW), .CW(CW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pop(pop), .distances(distances),
    .busy(busy), .done(done), .best_idx(best_idx), .second_idx(second_idx),
    .best_dist(best_dist), .second_dist(second_dist), .parent_a(parent_a),
    .parent_b(parent_b), .total_dist(total_dist)
  );

  task automatic load_inputs();
    for (int i = 0; i < N; i++) begin
      distances[i*DW +: DW] = DW'(dist_arr[i]);
      chrom[i] = {$urandom(), $urandom(), $urandom()};
      pop[i*CW +: CW] = chrom[i];
    end
  endtask

  // Full pass: pulse start, check busy/done timing, then compare results against the model.
  task automatic test_pass(input string name, input int restart_at);
    int exp_best, exp_second, exp_sum, done_cnt, done_at;
    exp_best = 0;
    for (int i = 1; i < N; i++) if (dist_arr[i] < dist_arr[exp_best]) exp_best = i;
    exp_second = (exp_best == 0) ? 1 : 0;
    for (int i = 0; i < N; i++)
      if (i != exp_best && dist_arr[i] < dist_arr[exp_second]) exp_second = i;
    exp_sum = 0;
`ifdef FITNESS_SUM_EN
    foreach (dist_arr[i]) exp_sum += dist_arr[i];
`endif
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    done_cnt = 0; done_at = -1;
    for (int c = 0; c < 45; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start = (c == restart_at);
      end
      if (c == 46) start = 1'b0;
      if (done) begin done_cnt++; if (done_at < 0) done_at = c; end
      if (c <= 25) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy c=%0d got %b want 1", name, c, busy); end
      end else if (c == 26) begin
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_in_done got %b want 0", name, busy); end
      end
      if (c == restart_at) begin @(posedge clk); #1 start = 1'b0; end
    end
    start = 1'b0;
    n_cmp++;
    if (done_cnt !== 1 || done_at !== 26) begin
      n_err++; $display("FAIL %s done_timing count=%0d at=%0d want 1 at 26", name, done_cnt, done_at);
    end
    n_cmp++;
    if (best_idx !== IW'(exp_best) || best_dist !== DW'(dist_arr[exp_best])) begin
      n_err++; $display("FAIL %s best got %0d/%0d want %0d/%0d", name, best_idx, best_dist, exp_best, dist_arr[exp_best]);
    end
    n_cmp++;
    if (second_idx !== IW'(exp_second) || second_dist !== DW'(dist_arr[exp_second])) begin
      n_err++; $display("FAIL %s second got %0d/%0d want %0d/%0d", name, second_idx, second_dist, exp_second, dist_arr[exp_second]);
    end
    n_cmp++;
    if (parent_a !== chrom[exp_best] || parent_b !== chrom[exp_second]) begin
      n_err++; $display("FAIL %s parents got %h/%h want %h/%h", name, parent_a, parent_b, chrom[exp_best], chrom[exp_second]);
    end
    n_cmp++;
    if (total_dist !== 17'(exp_sum)) begin
      n_err++; $display("FAIL %s total_dist got %0d want %0d", name, total_dist, exp_sum);
    end
  endtask

  task automatic test_reset();
    int seen_done;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (5) begin @(negedge clk); if (done) seen_done = 1; end
    n_cmp++;
    if ({busy, done, best_idx, second_idx, best_dist, second_dist} !== '0 ||
        parent_a !== '0 || parent_b !== '0 || total_dist !== '0 || seen_done !== 0) begin
      n_err++; $display("FAIL reset_state busy=%b done=%b best=%0d second=%0d total=%0d want all 0", busy, done, best_idx, second_idx, total_dist);
    end
  endtask

  task automatic test_descending();
    for (int i = 0; i < N; i++) dist_arr[i] = 1000 - 10*i;
    load_inputs();
    test_pass("descending", -1);
  endtask

  task automatic test_all_max();
    for (int i = 0; i < N; i++) dist_arr[i] = 4095;
    load_inputs();
    test_pass("all_max", -1);
  endtask

  task automatic test_ties();
    for (int i = 0; i < N; i++) dist_arr[i] = 900;
    dist_arr[7] = 5; dist_arr[3] = 5;
    load_inputs();
    test_pass("ties", -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) dist_arr[i] = (r < 3) ? $urandom_range(4095) : $urandom_range(20);
      load_inputs();
      test_pass("random", -1);
    end
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < N; i++) dist_arr[i] = $urandom_range(4095);
    load_inputs();
    test_pass("restart_ignored", 10);
  endtask

  task automatic test_reset_mid_scan();
    int seen_done;
    for (int i = 0; i < N; i++) dist_arr[i] = $urandom_range(4095);
    load_inputs();
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, best_idx, second_idx, best_dist, second_dist} !== '0 ||
        parent_a !== '0 || parent_b !== '0 || total_dist !== '0) begin
      n_err++; $display("FAIL reset_mid_scan busy=%b best=%0d second=%0d total=%0d want all 0", busy, best_idx, second_idx, total_dist);
    end
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (30) begin @(negedge clk); if (done) seen_done = 1; end
    n_cmp++;
    if (seen_done !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_no_done done_seen=%0d busy=%b want 0/0", seen_done, busy);
    end
    test_pass("after_reset", -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) dist_arr[i] = $urandom_range(4095);
    load_inputs();
    test_pass("back_to_back_a", -1);
    for (int i = 0; i < N; i++) dist_arr[i] = $urandom_range(4095);
    load_inputs();
    test_pass("back_to_back_b", -1);
  endtask

  initial begin
    test_reset();
    test_descending();
    test_all_max();
    test_ties();
    test_random();
    test_restart_ignored();
    test_reset_mid_scan();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
